// File: rtl/rr_select_ctrl.sv
// Round-robin controller for a 4:1 byte selector: picks a requesting channel,
// drives the selector code, captures the returned byte and holds it until accepted.
module rr_select_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] result_in,
  input  logic             out_ready,
  output logic [1:0]       select,
  output logic [3:0]       grant,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEL  = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [1:0]       select_nxt;
  logic [3:0]       grant_nxt;
  logic             valid_nxt;
  logic [WIDTH-1:0] data_nxt;

  logic [7:0]       req_dbl;
  logic [3:0]       req_rot;
  logic [1:0]       offset;
  logic [1:0]       win;

  // Rotate requests so bit 0 is the channel at ptr; first set bit wins.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[3:0];

  always_comb begin
    offset = 2'd0;
    casez (req_rot)
      4'b???1: offset = 2'd0;
      4'b??10: offset = 2'd1;
      4'b?100: offset = 2'd2;
      4'b1000: offset = 2'd3;
      default: offset = 2'd0;
    endcase
  end

  assign win  = ptr + offset;
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    select_nxt = select;
    grant_nxt  = 4'b0000;
    valid_nxt  = out_valid;
    data_nxt   = data_out;
    case (state)
      IDLE: begin
        if (|req) begin
          select_nxt = win;
          grant_nxt  = 4'b0001 << win;
          state_nxt  = SEL;
        end
      end
      SEL: begin
        data_nxt  = result_in;
        valid_nxt = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          valid_nxt = 1'b0;
          ptr_nxt   = select + 2'd1;
          state_nxt = IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      select    <= 2'd0;
      grant     <= 4'b0000;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      select    <= select_nxt;
      grant     <= grant_nxt;
      out_valid <= valid_nxt;
      data_out  <= data_nxt;
    end
  end

endmodule

// File: tb/tb_rr_select_ctrl.sv
// Directed and randomized bench for rr_select_ctrl against a transaction-level
// round-robin reference model with an external 4:1 selector lookup table.
module tb_rr_select_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [7:0] result_in;
  logic       out_ready = 1'b0;
  logic [1:0] select;
  logic [3:0] grant;
  logic       out_valid;
  logic [7:0] data_out;
  logic       busy;

  logic [7:0] tbl [4];

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0=waiting, 1=granted, 2=holding a byte
  int         m_phase;
  int         m_ptr;
  int         m_sel;
  logic [3:0] m_grant;
  logic       m_valid;
  logic [7:0] m_data;
  logic [3:0] last_grant;

  always #5 clk = ~clk;

  assign result_in = tbl[select];

  rr_select_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .result_in (result_in),
    .out_ready (out_ready),
    .select    (select),
    .grant     (grant),
    .out_valid (out_valid),
    .data_out  (data_out),
    .busy      (busy)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    cmp({tag, " select"}, {30'd0, select}, m_sel);
    cmp({tag, " grant"}, {28'd0, grant}, {28'd0, m_grant});
    cmp({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    cmp({tag, " data_out"}, {24'd0, data_out}, {24'd0, m_data});
    cmp({tag, " busy"}, {31'd0, busy}, (m_phase != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_sel = 0;
    m_grant = 4'b0000; m_valid = 1'b0; m_data = 8'h00;
    last_grant = 4'b0000;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset(input string tag);
    req = 4'b0000; out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, " in_reset"});
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check_all({tag, " after_reset"});
  endtask

  task automatic step(input logic [3:0] r, input logic rdy, input string tag);
    req = r; out_ready = rdy;
    #1;
    case (m_phase)
      0: begin
        m_grant = 4'b0000;
        if (r != 4'b0000) begin
          for (int k = 3; k >= 0; k--)
            if (r[(m_ptr + k) % 4]) m_sel = (m_ptr + k) % 4;
          m_grant = 4'b0001 << m_sel;
          m_phase = 1;
        end
      end
      1: begin
        m_data = tbl[m_sel]; m_valid = 1'b1; m_grant = 4'b0000; m_phase = 2;
      end
      default: begin
        m_grant = 4'b0000;
        if (rdy) begin
          m_valid = 1'b0; m_ptr = (m_sel + 1) % 4; m_phase = 0;
        end
      end
    endcase
    @(posedge clk); #1;
    check_all(tag);
    if (grant != 4'b0000) begin
      checks++;
      assert (!(grant == last_grant && (r & ~grant) != 4'b0000)) else begin
        errors++;
        $error("FAIL %s fairness: observed grant %b repeated, required other channel from req %b",
               tag, grant, r);
      end
      last_grant = grant;
    end
  endtask

  initial begin
    logic [3:0] exp_g [5];
    logic [7:0] exp_d [5];
    logic [3:0] rr;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44; exp_d[4] = 8'h11;
    for (int i = 0; i < 4; i++) tbl[i] = 8'($urandom);
    model_reset();
    #3;
    do_reset("init");

    // Single request on channel 2
    tbl[2] = 8'hA5;
    step(4'b0100, 1'b0, "single_req");
    cmp("single grant", {28'd0, grant}, 32'h4);
    cmp("single select", {30'd0, select}, 32'h2);
    step(4'b0000, 1'b0, "single_sel");
    cmp("single data", {24'd0, data_out}, 32'hA5);
    step(4'b0000, 1'b1, "single_accept");
    step(4'b1111, 1'b0, "single_ptr");
    cmp("single ptr3", {28'd0, grant}, 32'h8);
    step(4'b0000, 1'b1, "single_ptr_sel");
    step(4'b0000, 1'b1, "single_ptr_acc");

    // All channels requesting, pointer wraps
    do_reset("all_rst");
    tbl[0] = 8'h11; tbl[1] = 8'h22; tbl[2] = 8'h33; tbl[3] = 8'h44;
    for (int t = 0; t < 5; t++) begin
      step(4'b1111, 1'b1, "all_grant");
      cmp("all grant", {28'd0, grant}, {28'd0, exp_g[t]});
      step(4'b1111, 1'b1, "all_sel");
      cmp("all data", {24'd0, data_out}, {24'd0, exp_d[t]});
      step(4'b1111, 1'b1, "all_accept");
    end

    // Backpressure in HOLD
    tbl[m_ptr] = 8'h3C;
    step(4'b1111, 1'b0, "bp_grant");
    step(4'b0000, 1'b0, "bp_sel");
    for (int t = 0; t < 5; t++) begin
      step(4'b1010, 1'b0, "bp_hold");
      cmp("bp data", {24'd0, data_out}, 32'h3C);
    end
    step(4'b0000, 1'b1, "bp_release");
    cmp("bp valid_drop", {31'd0, out_valid}, 32'h0);

    // Fairness between ch0 and ch1 starting at ptr=1
    do_reset("fair_rst");
    step(4'b0001, 1'b1, "fair_pre"); step(4'b0001, 1'b1, "fair_pre"); step(4'b0001, 1'b1, "fair_pre");
    for (int t = 0; t < 3; t++) begin
      step(4'b0011, 1'b1, "fair_grant");
      cmp("fair grant", {28'd0, grant}, (t == 1) ? 32'h1 : 32'h2);
      step(4'b0011, 1'b1, "fair_sel");
      step(4'b0011, 1'b1, "fair_accept");
    end

    // Request withdrawn during SEL
    step(4'b0100, 1'b0, "wd_grant");
    step(4'b0000, 1'b0, "wd_sel");
    step(4'b0000, 1'b1, "wd_accept");
    for (int t = 0; t < 3; t++) step(4'b0000, 1'b1, "wd_idle");

    // Reset while holding a byte
    tbl[3] = 8'h5A;
    step(4'b1000, 1'b0, "mid_grant");
    step(4'b0000, 1'b0, "mid_sel");
    cmp("mid data", {24'd0, data_out}, 32'h5A);
    do_reset("mid_rst");
    step(4'b1000, 1'b1, "mid_regrant");
    cmp("mid regrant", {28'd0, grant}, 32'h8);
    step(4'b0000, 1'b1, "mid_sel2");
    step(4'b0000, 1'b1, "mid_accept2");

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset("rand_rst");
      end else begin
        if ($urandom_range(0, 7) == 0) tbl[$urandom_range(0, 3)] = 8'($urandom);
        rr = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
        step(rr, ($urandom_range(0, 2) != 0), "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
